// File: rtl/cva6_obi_port_arbiter.sv
// Round-robin arbiter that shares one OBI manager port among several requesters.
// An address phase that is presented but not yet granted is locked to its
// requester, so the payload stays stable. An in-order FIFO of source indices
// routes each downstream response back to the requester that issued it.
module cva6_obi_port_arbiter #(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  // upstream address phase
  input  logic                              port_req_i    [NumPorts],
  output logic                              port_gnt_o    [NumPorts],
  input  logic [AddrWidth-1:0]              port_addr_i   [NumPorts],
  input  logic                              port_we_i     [NumPorts],
  input  logic [DataWidth/8-1:0]            port_be_i     [NumPorts],
  input  logic [DataWidth-1:0]              port_wdata_i  [NumPorts],
  input  logic [IdWidth-1:0]                port_aid_i    [NumPorts],
  input  logic [5:0]                        port_atop_i   [NumPorts],
  // upstream response phase
  output logic                              port_rvalid_o [NumPorts],
  input  logic                              port_rready_i [NumPorts],
  output logic [DataWidth-1:0]              port_rdata_o  [NumPorts],
  output logic                              port_err_o    [NumPorts],
  output logic [IdWidth-1:0]                port_rid_o    [NumPorts],
  // downstream address phase
  output logic                              obi_req_o,
  input  logic                              obi_gnt_i,
  output logic [AddrWidth-1:0]              obi_addr_o,
  output logic                              obi_we_o,
  output logic [DataWidth/8-1:0]            obi_be_o,
  output logic [DataWidth-1:0]              obi_wdata_o,
  output logic [IdWidth-1:0]                obi_aid_o,
  output logic [5:0]                        obi_atop_o,
  // downstream response phase (in order)
  input  logic                              obi_rvalid_i,
  output logic                              obi_rready_o,
  input  logic [DataWidth-1:0]              obi_rdata_i,
  input  logic                              obi_err_i,
  input  logic [IdWidth-1:0]                obi_rid_i,
  // status
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                              rsp_unexpected_o
);

  localparam int unsigned IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            unexp_q, unexp_d;

  logic            win_vld;
  logic [IdxW-1:0] win_idx;
  logic [IdxW-1:0] head_idx;
  logic            full, empty, push, pop;

  // Port index base+off, wrapped modulo the number of ports.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base, input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % NumPorts;
    return s[IdxW-1:0];
  endfunction

  // FIFO pointer increment; depth is a power of two so natural overflow wraps.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (MaxOutstanding == 1) ? '0 : p + PtrW'(1);
  endfunction

  assign full     = (count_q == CntW'(MaxOutstanding));
  assign empty    = (count_q == '0);
  assign head_idx = fifo_q[rptr_q];
  assign push     = obi_req_o & obi_gnt_i;
  assign pop      = obi_rvalid_i & obi_rready_o & ~empty;

  // Winner selection: locked requester first, else scan from rr_q+1 (last write wins = highest priority).
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_q;
    if (lock_q) begin
      win_vld = 1'b1;
      win_idx = lock_idx_q;
    end else begin
      for (int unsigned i = NumPorts; i >= 1; i--) begin
        if (port_req_i[wrap_add(rr_q, i)]) begin
          win_vld = 1'b1;
          win_idx = wrap_add(rr_q, i);
        end
      end
    end
  end

  // Downstream address phase and upstream grants; payload is zero when nobody is selected.
  always_comb begin
    obi_req_o   = win_vld & port_req_i[win_idx] & ~full;
    obi_addr_o  = '0;
    obi_we_o    = 1'b0;
    obi_be_o    = '0;
    obi_wdata_o = '0;
    obi_aid_o   = '0;
    obi_atop_o  = '0;
    port_gnt_o  = '{default: 1'b0};
    if (win_vld) begin
      obi_addr_o  = port_addr_i[win_idx];
      obi_we_o    = port_we_i[win_idx];
      obi_be_o    = port_be_i[win_idx];
      obi_wdata_o = port_wdata_i[win_idx];
      obi_aid_o   = port_aid_i[win_idx];
      obi_atop_o  = port_atop_i[win_idx];
    end
    port_gnt_o[win_idx] = obi_req_o & obi_gnt_i;
  end

  // Response routing to the FIFO head; with nothing tracked, responses are drained and dropped.
  always_comb begin
    port_rvalid_o = '{default: 1'b0};
    port_rdata_o  = '{default: '0};
    port_err_o    = '{default: 1'b0};
    port_rid_o    = '{default: '0};
    obi_rready_o  = 1'b0;
    if (empty) begin
      obi_rready_o = obi_rvalid_i;
    end else begin
      obi_rready_o            = port_rready_i[head_idx];
      port_rvalid_o[head_idx] = obi_rvalid_i;
      port_rdata_o[head_idx]  = obi_rdata_i;
      port_err_o[head_idx]    = obi_err_i;
      port_rid_o[head_idx]    = obi_rid_i;
    end
  end

  // Next state for round-robin pointer, lock, FIFO pointers and occupancy.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    unexp_d    = obi_rvalid_i & empty;
    if (push) begin
      rr_d   = win_idx;
      lock_d = 1'b0;
      wptr_d = ptr_inc(wptr_q);
    end else if (obi_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = win_idx;
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= IdxW'(NumPorts - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      unexp_q    <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      unexp_q    <= unexp_d;
    end
  end

  // Source-index storage; entries are only meaningful between push and pop.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q] <= win_idx;
    end
  end

  assign outstanding_o    = count_q;
  assign rsp_unexpected_o = unexp_q;

endmodule
